barrel_motion_ctrl: RTL and testbench

Motion and animation sequencer for one barrel sprite. On each frame tick it advances the barrel along a zig-zag course of platforms: roll, fall at the platform edge, then roll back the other way, until it leaves the screen at the floor level. It drives the barrel sprite colour lookup with the top-left position (`posx`/`posy`) and a 3-bit sprite frame select (`animate_state`), plus an `active` flag for collision and priority logic.

---
 rtl/barrel_motion_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_barrel_motion_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/barrel_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : barrel_motion_ctrl
// Purpose  : Motion and animation sequencer for a single barrel sprite. On
//            each frame tick the barrel rolls along a platform, drops to the
//            next platform at the edge, and rolls back the other way. It
//            leaves the screen when it reaches the edge of the floor platform.
// Revision : 1.0 - initial release
//
// Ports
//   clk              in   system clock, single domain
//   rst              in   synchronous active-high reset
//   frame_tick_i     in   one-cycle pulse per video frame
//   spawn_i          in   start a barrel; honoured only while idle
//   halt_i           in   freeze motion (present only with BARREL_HALT_EN)
//   posx_o     [9:0] out  sprite left column
//   posy_o     [8:0] out  sprite top row
//   animate_state_o [2:0] out  000-011 roll frames, 100/101 fall frames
//   active_o         out  barrel is on screen
//
// Build option
//   BARREL_HALT_EN : when defined, adds halt_i; ticks are ignored while it
//                    is high (spawn in idle still works).
// ============================================================================
module barrel_motion_ctrl #(
  parameter logic [9:0] START_X     = 10'd100,
  parameter logic [8:0] START_Y     = 9'd80,
  parameter logic [8:0] LEVEL_DROP  = 9'd80,
  parameter logic [8:0] FLOOR_Y     = 9'd400,
  parameter logic [9:0] RIGHT_LIMIT = 10'd560,
  parameter logic [9:0] LEFT_LIMIT  = 10'd40,
  parameter int         ROLL_STEP   = 2,
  parameter int         FALL_STEP   = 4,
  parameter int         ANIM_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick_i,
  input  logic       spawn_i,
`ifdef BARREL_HALT_EN
  input  logic       halt_i,
`endif
  output logic [9:0] posx_o,
  output logic [8:0] posy_o,
  output logic [2:0] animate_state_o,
  output logic       active_o
);

  localparam int         CNT_W       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [9:0] ROLL_STEP_X = 10'(ROLL_STEP);
  localparam logic [8:0] FALL_STEP_Y = 9'(FALL_STEP);
  // The fall sprite is 42 wide vs 32 for rolling; shifting by 5 keeps the
  // two sprites centred on each other.
  localparam logic [9:0] FALL_OFFSET = 10'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROLL = 2'd1,
    S_FALL = 2'd2
  } state_e;

  state_e           state_q;
  logic             dir_q;        // 0 = rolling right, 1 = rolling left
  logic [1:0]       frame_q;
  logic [CNT_W-1:0] anim_cnt_q;
  logic [8:0]       target_y_q;
  logic [9:0]       posx_q;
  logic [8:0]       posy_q;
  logic [2:0]       animate_q;
  logic             active_q;

  logic             tick_en;
  logic             cnt_wrap;
  logic [CNT_W-1:0] anim_cnt_d;
  logic [1:0]       frame_d;
  logic [10:0]      x_plus;
  logic             right_edge;
  logic             left_edge;
  logic             at_edge;
  logic [9:0]       y_plus;
  logic             land;

`ifdef BARREL_HALT_EN
  assign tick_en = frame_tick_i & ~halt_i;
`else
  assign tick_en = frame_tick_i;
`endif

  assign cnt_wrap   = (anim_cnt_q == CNT_W'(ANIM_DIV - 1));
  assign anim_cnt_d = cnt_wrap ? '0 : anim_cnt_q + CNT_W'(1);
  // Rolling left plays the frames in reverse so the barrel appears to spin
  // the other way; the 2-bit counter wraps naturally.
  assign frame_d    = !cnt_wrap ? frame_q :
                      (dir_q ? frame_q - 2'd1 : frame_q + 2'd1);

  // Widened sums so edge/landing comparisons never wrap.
  assign x_plus     = {1'b0, posx_q} + {1'b0, ROLL_STEP_X};
  assign right_edge = (x_plus >= {1'b0, RIGHT_LIMIT});
  assign left_edge  = ({1'b0, posx_q} <= ({1'b0, LEFT_LIMIT} + {1'b0, ROLL_STEP_X}));
  assign at_edge    = dir_q ? left_edge : right_edge;
  assign y_plus     = {1'b0, posy_q} + {1'b0, FALL_STEP_Y};
  assign land       = (y_plus >= {1'b0, target_y_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dir_q      <= 1'b0;
      frame_q    <= 2'd0;
      anim_cnt_q <= '0;
      target_y_q <= 9'd0;
      posx_q     <= 10'd0;
      posy_q     <= 9'd0;
      animate_q  <= 3'b000;
      active_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A tick coinciding with spawn produces no motion.
          if (spawn_i) begin
            posx_q     <= START_X;
            posy_q     <= START_Y;
            dir_q      <= 1'b0;
            frame_q    <= 2'd0;
            anim_cnt_q <= '0;
            animate_q  <= 3'b000;
            active_q   <= 1'b1;
            state_q    <= S_ROLL;
          end
        end

        S_ROLL: begin
          if (tick_en) begin
            anim_cnt_q <= anim_cnt_d;
            frame_q    <= frame_d;
            if (at_edge) begin
              if (posy_q == FLOOR_Y) begin
                // Off the end of the floor: position and frame freeze.
                active_q <= 1'b0;
                state_q  <= S_IDLE;
              end else begin
                posx_q     <= dir_q ? (LEFT_LIMIT - FALL_OFFSET)
                                    : (RIGHT_LIMIT - FALL_OFFSET);
                target_y_q <= posy_q + LEVEL_DROP;
                animate_q  <= 3'b100;
                anim_cnt_q <= '0;
                state_q    <= S_FALL;
              end
            end else begin
              posx_q    <= dir_q ? (posx_q - ROLL_STEP_X) : x_plus[9:0];
              animate_q <= {1'b0, frame_d};
            end
          end
        end

        S_FALL: begin
          if (tick_en) begin
            if (land) begin
              posy_q     <= target_y_q;
              posx_q     <= posx_q + FALL_OFFSET;
              dir_q      <= ~dir_q;
              frame_q    <= 2'd0;
              animate_q  <= 3'b000;
              anim_cnt_q <= '0;
              state_q    <= S_ROLL;
            end else begin
              posy_q     <= y_plus[8:0];
              anim_cnt_q <= anim_cnt_d;
              if (cnt_wrap) begin
                animate_q <= {2'b10, ~animate_q[0]};
              end
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign posx_o          = posx_q;
  assign posy_o          = posy_q;
  assign animate_state_o = animate_q;
  assign active_o        = active_q;

endmodule
`default_nettype wire

// File: tb/tb_barrel_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrel_motion_ctrl
// Purpose  : Randomized self-checking bench for barrel_motion_ctrl with a
//            behavioural course model; directed checks on the key waypoints.
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_motion_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       spawn;
  logic       halt;
  logic [9:0] posx;
  logic [8:0] posy;
  logic [2:0] anim;
  logic       active;

  int n_checks;
  int n_fail;

  // Behavioural model: phase 0 idle, 1 roll, 2 fall
  int m_phase, m_x, m_y, m_dir, m_frame, m_cnt, m_anim, m_act, m_tgt;

  barrel_motion_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick_i    (frame_tick),
    .spawn_i         (spawn),
`ifdef BARREL_HALT_EN
    .halt_i          (halt),
`endif
    .posx_o          (posx),
    .posy_o          (posy),
    .animate_state_o (anim),
    .active_o        (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit tk, input bit sp, input bit rs, input bit hl);
    bit edge_hit;
    if (rs) begin
      m_phase = 0; m_x = 0; m_y = 0; m_dir = 0; m_frame = 0;
      m_cnt = 0; m_anim = 0; m_act = 0; m_tgt = 0;
    end else if (m_phase == 0) begin
      if (sp) begin
        m_phase = 1; m_x = 100; m_y = 80; m_dir = 0; m_frame = 0;
        m_cnt = 0; m_anim = 0; m_act = 1;
      end
    end else if (tk && !hl) begin
      if (m_phase == 1) begin
        m_cnt = (m_cnt + 1) % 4;
        if (m_cnt == 0) m_frame = m_dir ? (m_frame + 3) % 4 : (m_frame + 1) % 4;
        edge_hit = m_dir ? (m_x <= 42) : (m_x + 2 >= 560);
        if (edge_hit) begin
          if (m_y == 400) begin
            m_phase = 0; m_act = 0;
          end else begin
            m_x = m_dir ? 35 : 555;
            m_tgt = m_y + 80; m_anim = 4; m_cnt = 0; m_phase = 2;
          end
        end else begin
          m_x = m_dir ? m_x - 2 : m_x + 2;
          m_anim = m_frame;
        end
      end else begin
        if (m_y + 4 >= m_tgt) begin
          m_y = m_tgt; m_x = m_x + 5; m_dir = 1 - m_dir; m_frame = 0;
          m_anim = 0; m_cnt = 0; m_phase = 1;
        end else begin
          m_y = m_y + 4;
          m_cnt = (m_cnt + 1) % 4;
          if (m_cnt == 0) m_anim = (m_anim == 4) ? 5 : 4;
        end
      end
    end
  endtask

  task automatic cycle(input bit tk, input bit sp, input bit rs, input bit hl);
    @(negedge clk);
    frame_tick = tk; spawn = sp; rst = rs; halt = hl;
    @(posedge clk);
    model_step(tk, sp, rs, hl);
    #1;
    check_val("posx", int'(posx), m_x);
    check_val("posy", int'(posy), m_y);
    check_val("anim", int'(anim), m_anim);
    check_val("active", int'(active), m_act);
  endtask

  initial begin
    int guard;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; frame_tick = 1'b0; spawn = 1'b0; halt = 1'b0;
    m_phase = 0; m_x = 0; m_y = 0; m_dir = 0; m_frame = 0;
    m_cnt = 0; m_anim = 0; m_act = 0; m_tgt = 0;

    // Reset state
    repeat (3) cycle(0, 0, 1, 0);
    check_val("rst_posx", int'(posx), 0);
    check_val("rst_active", int'(active), 0);

    // Spawn, then first animation frame after 4 ticks
    cycle(0, 1, 0, 0);
    check_val("spawn_posx", int'(posx), 100);
    check_val("spawn_posy", int'(posy), 80);
    check_val("spawn_active", int'(active), 1);
    repeat (4) cycle(1, 0, 0, 0);
    check_val("roll4_posx", int'(posx), 108);
    check_val("roll4_anim", int'(anim), 1);

    // Right edge at tick 230
    repeat (226) cycle(1, 0, 0, 0);
    check_val("edge_posx", int'(posx), 555);
    check_val("edge_posy", int'(posy), 80);
    check_val("edge_anim", int'(anim), 4);
    check_val("edge_active", int'(active), 1);

    // Fall and land, then reverse roll
    repeat (20) cycle(1, 0, 0, 0);
    check_val("land_posy", int'(posy), 160);
    check_val("land_posx", int'(posx), 560);
    check_val("land_anim", int'(anim), 0);
    cycle(1, 0, 0, 0);
    check_val("rev1_posx", int'(posx), 558);
    repeat (3) cycle(1, 0, 0, 0);
    check_val("rev4_anim", int'(anim), 3);

    // Random ticks and ignored spawns until the barrel leaves the floor
    guard = 0;
    while (m_act == 1 && guard < 8000) begin
      cycle(($urandom % 3) != 0, ($urandom % 8) == 0, 0, 0);
      guard++;
    end
    check_val("exit_active", int'(active), 0);
    check_val("exit_posy", int'(posy), 400);
    repeat (5) cycle(1, 0, 0, 0);
    check_val("idle_stays", int'(active), 0);

    // Respawn restarts the course
    cycle(1, 1, 0, 0);
    check_val("respawn_posx", int'(posx), 100);
    check_val("respawn_posy", int'(posy), 80);

`ifdef BARREL_HALT_EN
    begin
      int hx;
      int ha;
      repeat (20) cycle(1, 0, 0, 0);
      hx = m_x; ha = m_anim;
      repeat (10) cycle(1, 0, 0, 1);
      check_val("halt_posx", int'(posx), hx);
      check_val("halt_anim", int'(anim), ha);
      cycle(1, 0, 0, 0);
      check_val("resume_posx", int'(posx), hx + 2);
    end
`endif

    // Reach a fall, try a spawn mid-fall, then reset
    guard = 0;
    while (m_phase != 2 && guard < 400) begin
      cycle(1, 0, 0, 0);
      guard++;
    end
    check_val("reach_fall_anim", int'(anim[2]), 1);
    repeat (3) cycle(1, 1, 0, 0);
    check_val("spawn_ignored_active", int'(active), 1);
    cycle(1, 0, 1, 0);
    check_val("midrst_posx", int'(posx), 0);
    check_val("midrst_posy", int'(posy), 0);
    check_val("midrst_anim", int'(anim), 0);
    check_val("midrst_active", int'(active), 0);
    cycle(1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
